// File: rtl/common.sv
// Shared data-bus types and responder constants.
// Used by the MEM stage and by the on-chip memory responders.
package common;

  typedef enum logic [1:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4,
    MSIZE8
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  localparam int RESP_MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dresp_state_t;

endpackage

// File: rtl/dbus_sram_responder_sram.sv
// Single-port 64-bit SRAM with byte-enable write.
// Read data is registered and only changes on a read.
module sram_1rw_be #(
  parameter int    WORDS     = 4096,
  parameter int    AW        = 12,
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder with programmable latency.
// One transaction at a time; sticky err on bad address or protocol.
module dbus_sram_responder
  import common::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       err
);

  localparam int AW = $clog2(MEM_WORDS);

  dresp_state_t state, nstate;
  logic [3:0]   cnt, cnt_n;
  dbus_req_t    lat;
  logic         ok;
  logic         rd_sel;

  logic [63:0]  op_addr, op_data, off;
  msize_t       op_size;
  logic [7:0]   op_strb;
  logic         in_rng, mis, good;
  logic         enter, viol, mem_en;
  logic [63:0]  q;

  // in IDLE the live request is the one about to be committed
  always_comb begin
    op_addr = lat.addr;
    op_size = lat.size;
    op_strb = lat.strobe;
    op_data = lat.data;
    if (state == IDLE) begin
      op_addr = dreq.addr;
      op_size = dreq.size;
      op_strb = dreq.strobe;
      op_data = dreq.data;
    end
  end

  // address range and alignment checks
  always_comb begin
    off    = op_addr - BASE_ADDR;
    in_rng = (op_addr >= BASE_ADDR) &&
             (off < (64'(MEM_WORDS) << 3));
    mis    = 1'b0;
    unique case (op_size)
      MSIZE1:  mis = 1'b0;
      MSIZE2:  mis = op_addr[0];
      MSIZE4:  mis = |op_addr[1:0];
      MSIZE8:  mis = |op_addr[2:0];
      default: mis = 1'b1;
    endcase
    good = in_rng && !mis;
  end

  // next state and latency counter
  always_comb begin
    nstate = state;
    cnt_n  = cnt;
    unique case (state)
      IDLE: begin
        if (dreq.valid) begin
          if (LATENCY == 1) begin
            nstate = RESP;
          end else begin
            nstate = WAIT;
            cnt_n  = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) nstate = RESP;
        else cnt_n = cnt - 4'd1;
      end
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // commit strobes and initiator hold check
  always_comb begin
    enter  = (nstate == RESP);
    mem_en = enter && good && reset;
    viol   = (state != IDLE) && (dreq != lat);
  end

  sram_1rw_be #(
    .WORDS     (MEM_WORDS),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_sram (
    .clk   (clk),
    .en    (mem_en),
    .we    (|op_strb),
    .be    (op_strb),
    .addr  (off[AW+2:3]),
    .wdata (op_data),
    .rdata (q)
  );

  // FSM, request latch, response and error registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      lat    <= '0;
      ok     <= 1'b0;
      rd_sel <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= cnt_n;
      ok    <= enter;
      if (state == IDLE && dreq.valid) lat <= dreq;
      if (enter) rd_sel <= good && !(|op_strb);
      if ((enter && !good) || viol) err <= 1'b1;
    end
  end

  // single-phase bus: addr_ok mirrors data_ok
  always_comb begin
    dresp.addr_ok = ok;
    dresp.data_ok = ok;
    dresp.data    = rd_sel ? q : 64'h0;
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder at LATENCY 2, 1 and 15.
// Vector table plus hand sequences for reset and hold violations.
module tb_dbus_sram_responder;
  import common::*;

  typedef struct {
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strb;
    logic [63:0] data;
    logic [63:0] exp;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic       clk;
  logic       reset;
  dbus_req_t  rq [3];
  dbus_resp_t rs [3];
  logic       er [3];

  int   checks = 0;
  int   errors = 0;
  exp_t sbq [$];
  vec_t tbl [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dbus_sram_responder #(
      .LATENCY (g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .dreq  (rq[g]),
      .dresp (rs[g]),
      .err   (er[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic req(input int k, input logic [63:0] a,
                     input msize_t sz, input logic [7:0] sb,
                     input logic [63:0] d, input logic [63:0] ex,
                     input logic ee);
    int   n;
    int   lt;
    exp_t e;
    lt = (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    rq[k] = '{valid: 1'b1, addr: a, size: sz, strobe: sb, data: d};
    sbq.push_back('{data: ex, err: ee});
    n = 0;
    do begin
      tick();
      n++;
    end while (!rs[k].data_ok && n < 40);
    chk("latency", 64'(n), 64'(lt));
    e = sbq.pop_front();
    if (rs[k].data_ok) begin
      chk("data", rs[k].data, e.data);
      chk("err", 64'(er[k]), 64'(e.err));
      chk("addr_ok", 64'(rs[k].addr_ok), 64'd1);
    end
    tick();
    rq[k].valid = 1'b0;
    chk("one_cycle", 64'(rs[k].data_ok), 64'd0);
    chk("hold", rs[k].data, e.data);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) rq[i].valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int spur;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) rq[i] = '0;

    tbl.push_back('{64'h8000_0010, MSIZE8, 8'hFF,
      64'h1122334455667788, 64'h0, 1'b0});
    tbl.push_back('{64'h8000_0010, MSIZE8, 8'h00,
      64'h0, 64'h1122334455667788, 1'b0});
    tbl.push_back('{64'h8000_0012, MSIZE1, 8'h04,
      64'h0000_0000_00AB_0000, 64'h0, 1'b0});
    tbl.push_back('{64'h8000_0010, MSIZE8, 8'h00,
      64'h0, 64'h1122334455AB7788, 1'b0});
    tbl.push_back('{64'h8000_0018, MSIZE8, 8'hFF,
      64'hCAFEBABE_DEADBEEF, 64'h0, 1'b0});
    tbl.push_back('{64'h8000_001C, MSIZE4, 8'h00,
      64'h0, 64'hCAFEBABE_DEADBEEF, 1'b0});
    tbl.push_back('{64'h8000_0020, MSIZE8, 8'hFF,
      64'h0123456789ABCDEF, 64'h0, 1'b0});
    tbl.push_back('{64'h8000_7FF8, MSIZE8, 8'hFF,
      64'h5555AAAA5555AAAA, 64'h0, 1'b0});
    tbl.push_back('{64'h8000_7FF8, MSIZE8, 8'h00,
      64'h0, 64'h5555AAAA5555AAAA, 1'b0});
    tbl.push_back('{64'h8000_0000, MSIZE8, 8'hFF,
      64'hA5A5A5A5A5A5A5A5, 64'h0, 1'b0});
    tbl.push_back('{64'h0000_1000, MSIZE8, 8'h00,
      64'h0, 64'h0, 1'b1});
    tbl.push_back('{64'h8000_0011, MSIZE2, 8'h00,
      64'h0, 64'h0, 1'b1});
    tbl.push_back('{64'h8000_8000, MSIZE8, 8'hFF,
      64'hBBBBBBBBBBBBBBBB, 64'h0, 1'b1});
    tbl.push_back('{64'h8000_0000, MSIZE8, 8'h00,
      64'h0, 64'hA5A5A5A5A5A5A5A5, 1'b1});
    tbl.push_back('{64'h8000_0016, MSIZE2, 8'h00,
      64'h0, 64'h1122334455AB7788, 1'b1});

    do_reset();
    chk("rst_resp", 64'(rs[0].addr_ok | rs[0].data_ok), 64'd0);
    chk("rst_data", rs[0].data, 64'h0);
    chk("rst_err", 64'(er[0]), 64'd0);
    spur = 0;
    repeat (20) begin
      tick();
      for (int i = 0; i < 3; i++) if (rs[i].data_ok) spur++;
    end
    chk("spurious", 64'(spur), 64'd0);

    foreach (tbl[i]) begin
      req(0, tbl[i].addr, tbl[i].size, tbl[i].strb,
          tbl[i].data, tbl[i].exp, tbl[i].exp_err);
    end

    do_reset();
    chk("err_clr", 64'(er[0]), 64'd0);
    rq[0] = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8,
              strobe: 8'h00, data: 64'h0};
    tick();
    rq[0].addr = 64'h8000_0018;
    tick();
    chk("viol_ok", 64'(rs[0].data_ok), 64'd1);
    chk("viol_data", rs[0].data, 64'h1122334455AB7788);
    chk("viol_err", 64'(er[0]), 64'd1);
    tick();
    rq[0].valid = 1'b0;

    do_reset();
    rq[0] = '{valid: 1'b1, addr: 64'h8000_0010, size: MSIZE8,
              strobe: 8'h00, data: 64'h0};
    repeat (2) tick();
    chk("resp_ok", 64'(rs[0].data_ok), 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_ok_fall", 64'(rs[0].data_ok), 64'd0);
    chk("rst_data_fall", rs[0].data, 64'h0);
    rq[0].valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    req(0, 64'h8000_0010, MSIZE8, 8'h00, 64'h0,
        64'h1122334455AB7788, 1'b0);
    rq[0] = '{valid: 1'b1, addr: 64'h8000_0020, size: MSIZE8,
              strobe: 8'hFF, data: 64'hDEAD};
    tick();
    reset = 1'b0;
    #1;
    chk("rst_wait", 64'(rs[0]), 66'h0);
    rq[0].valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_quiet", 64'(rs[0].data_ok), 64'd0);
    req(0, 64'h8000_0020, MSIZE8, 8'h00, 64'h0,
        64'h0123456789ABCDEF, 1'b0);

    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        req(k, 64'h8000_0040 + 64'(8 * i), MSIZE8, 8'hFF,
            64'h1000 * 64'(k) + 64'(i), 64'h0, 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
        req(k, 64'h8000_0040 + 64'(8 * i), MSIZE8, 8'h00, 64'h0,
            64'h1000 * 64'(k) + 64'(i), 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
